// File: rtl/load_align_unit_pkg.sv
// Shared definitions for the MEM-stage load path: load opcodes, exception codes,
// FSM state encoding and small decode helpers.
package load_align_unit_pkg;

   // Load opcodes (also used by the store byte-enable logic)
   localparam logic [5:0] OP_LB  = 6'h20;
   localparam logic [5:0] OP_LH  = 6'h21;
   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_LBU = 6'h24;
   localparam logic [5:0] OP_LHU = 6'h25;

   localparam logic [1:0] EXC_NONE = 2'b00;
   localparam logic [1:0] EXC_ADEL = 2'b01;
   localparam logic [1:0] EXC_BUS  = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2,
      ST_EXC  = 2'd3
   } state_t;

   function automatic logic is_load_op(input logic [5:0] op);
      logic legal;
      legal = 1'b0;
      case (op)
         OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: legal = 1'b1;
         default:                             legal = 1'b0;
      endcase
      return legal;
   endfunction

   // Words need a 4-byte boundary, halfwords a 2-byte boundary, bytes anything.
   function automatic logic is_aligned(input logic [5:0] op, input logic [1:0] off);
      logic ok;
      ok = 1'b1;
      case (op)
         OP_LW:         ok = (off == 2'b00);
         OP_LH, OP_LHU: ok = ~off[0];
         default:       ok = 1'b1;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/load_align_unit_extend.sv
// Byte/halfword lane selection and sign/zero extension of a little-endian read word.
module load_extend
   import load_align_unit_pkg::*;
(
   input  logic [5:0]  op,
   input  logic [1:0]  off,
   input  logic [31:0] word,
   output logic [31:0] ext
);

   logic [7:0]  lane [4];
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         assign lane[gi] = word[8*gi +: 8];
      end
   endgenerate

   assign byte_sel = lane[off];
   assign half_sel = off[1] ? word[31:16] : word[15:0];

   always_comb begin
      ext = word;
      case (op)
         OP_LB:   ext = {{24{byte_sel[7]}}, byte_sel};
         OP_LBU:  ext = {24'h000000, byte_sel};
         OP_LH:   ext = {{16{half_sel[15]}}, half_sel};
         OP_LHU:  ext = {16'h0000, half_sel};
         default: ext = word;
      endcase
   end

endmodule

// File: rtl/load_align_unit.sv
// MEM-stage load unit: issues a word read over req/ack, stalls until the data
// returns, then aligns/extends it for WB; flags misaligned loads and bus timeouts.
module load_align_unit
   import load_align_unit_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        ld_valid,
   input  logic [5:0]  ld_op,
   input  logic [31:0] ld_addr,
   input  logic [4:0]  ld_rd,
   output logic        ld_stall,
   output logic        dm_req,
   output logic [31:0] dm_addr,
   input  logic        dm_ack,
   input  logic [31:0] dm_rdata,
   output logic        wb_valid,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic        ld_exc,
   output logic [1:0]  exc_code,
   output logic [31:0] exc_addr
);

   localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [5:0]  op_q, op_d;
   logic [31:0] addr_q, addr_d;
   logic [4:0]  rd_q, rd_d;

   logic        dm_req_q, dm_req_d;
   logic [31:0] dm_addr_q, dm_addr_d;
   logic        wb_valid_q, wb_valid_d;
   logic [4:0]  wb_rd_q, wb_rd_d;
   logic [31:0] wb_data_q, wb_data_d;
   logic        ld_exc_q, ld_exc_d;
   logic [1:0]  exc_code_q, exc_code_d;
   logic [31:0] exc_addr_q, exc_addr_d;

   logic        ld_legal;
   logic        ld_aligned;
   logic        accept;
   logic        adel;
   logic [31:0] ext_data;

   load_extend u_extend (
      .op   (op_q),
      .off  (addr_q[1:0]),
      .word (dm_rdata),
      .ext  (ext_data)
   );

   assign ld_legal   = ld_valid & is_load_op(ld_op);
   assign ld_aligned = is_aligned(ld_op, ld_addr[1:0]);
   assign accept     = (state_q == ST_IDLE) & ld_legal & ld_aligned;
   assign adel       = (state_q == ST_IDLE) & ld_legal & ~ld_aligned;

   // Released in DONE/EXC so MEM advances in the same cycle the pulse appears
   assign ld_stall = accept | (state_q == ST_WAIT);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      op_d       = op_q;
      addr_d     = addr_q;
      rd_d       = rd_q;
      dm_addr_d  = dm_addr_q;
      wb_rd_d    = wb_rd_q;
      wb_data_d  = wb_data_q;
      exc_addr_d = exc_addr_q;
      exc_code_d = EXC_NONE;
      wb_valid_d = 1'b0;
      ld_exc_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               op_d      = ld_op;
               addr_d    = ld_addr;
               rd_d      = ld_rd;
               dm_addr_d = {ld_addr[31:2], 2'b00};
               cnt_d     = 8'd0;
               state_d   = ST_WAIT;
            end else if (adel) begin
               exc_addr_d = ld_addr;
               exc_code_d = EXC_ADEL;
               ld_exc_d   = 1'b1;
               state_d    = ST_EXC;
            end
         end
         ST_WAIT: begin
            // An ack in the final allowed cycle still completes the load
            if (dm_ack) begin
               wb_data_d  = ext_data;
               wb_rd_d    = rd_q;
               wb_valid_d = 1'b1;
               cnt_d      = 8'd0;
               state_d    = ST_DONE;
            end else if (cnt_q + 8'd1 == TIMEOUT_LIM) begin
               exc_addr_d = addr_q;
               exc_code_d = EXC_BUS;
               ld_exc_d   = 1'b1;
               cnt_d      = 8'd0;
               state_d    = ST_EXC;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         ST_EXC:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      dm_req_d = (state_d == ST_WAIT);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= 8'd0;
         op_q       <= 6'd0;
         addr_q     <= 32'd0;
         rd_q       <= 5'd0;
         dm_req_q   <= 1'b0;
         dm_addr_q  <= 32'd0;
         wb_valid_q <= 1'b0;
         wb_rd_q    <= 5'd0;
         wb_data_q  <= 32'd0;
         ld_exc_q   <= 1'b0;
         exc_code_q <= EXC_NONE;
         exc_addr_q <= 32'd0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         op_q       <= op_d;
         addr_q     <= addr_d;
         rd_q       <= rd_d;
         dm_req_q   <= dm_req_d;
         dm_addr_q  <= dm_addr_d;
         wb_valid_q <= wb_valid_d;
         wb_rd_q    <= wb_rd_d;
         wb_data_q  <= wb_data_d;
         ld_exc_q   <= ld_exc_d;
         exc_code_q <= exc_code_d;
         exc_addr_q <= exc_addr_d;
      end
   end

   assign dm_req   = dm_req_q;
   assign dm_addr  = dm_addr_q;
   assign wb_valid = wb_valid_q;
   assign wb_rd    = wb_rd_q;
   assign wb_data  = wb_data_q;
   assign ld_exc   = ld_exc_q;
   assign exc_code = exc_code_q;
   assign exc_addr = exc_addr_q;

endmodule

// File: tb/tb_load_align_unit.sv
// Bench for load_align_unit: directed vectors plus random loads against a
// transaction-level reference; a second instance with a short timeout.
module tb_load_align_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        ld_valid;
   logic [5:0]  ld_op;
   logic [31:0] ld_addr;
   logic [4:0]  ld_rd;
   logic        dm_ack;
   logic [31:0] dm_rdata;

   logic        ld_stall, dm_req, wb_valid, ld_exc;
   logic [31:0] dm_addr, wb_data, exc_addr;
   logic [4:0]  wb_rd;
   logic [1:0]  exc_code;

   logic        to_ld_stall, to_dm_req, to_wb_valid, to_ld_exc;
   logic [31:0] to_dm_addr, to_wb_data, to_exc_addr;
   logic [4:0]  to_wb_rd;
   logic [1:0]  to_exc_code;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   load_align_unit dut (
      .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_op(ld_op),
      .ld_addr(ld_addr), .ld_rd(ld_rd), .ld_stall(ld_stall), .dm_req(dm_req),
      .dm_addr(dm_addr), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
      .ld_exc(ld_exc), .exc_code(exc_code), .exc_addr(exc_addr)
   );

   load_align_unit #(.TIMEOUT_CYCLES(4)) dut_to (
      .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_op(ld_op),
      .ld_addr(ld_addr), .ld_rd(ld_rd), .ld_stall(to_ld_stall), .dm_req(to_dm_req),
      .dm_addr(to_dm_addr), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
      .wb_valid(to_wb_valid), .wb_rd(to_wb_rd), .wb_data(to_wb_data),
      .ld_exc(to_ld_exc), .exc_code(to_exc_code), .exc_addr(to_exc_addr)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Inputs change 1 ns after the edge; outputs are sampled 4 ns after the edge.
   task automatic next_cycle;
      @(posedge clk);
      #1;
   endtask

   task automatic settle;
      #3;
   endtask

   function automatic int op_size(input logic [5:0] op);
      case (op)
         6'h23:        return 4;
         6'h21, 6'h25: return 2;
         6'h20, 6'h24: return 1;
         default:      return 0;
      endcase
   endfunction

   function automatic logic [31:0] ref_extend(input logic [5:0] op, input logic [31:0] addr,
                                              input logic [31:0] word);
      logic [31:0] sh;
      logic [31:0] v;
      sh = word >> (8 * addr[1:0]);
      v  = word;
      case (op)
         6'h20: begin v = sh % 256;   if (v >= 128)   v = v - 256;   end
         6'h24: v = sh % 256;
         6'h21: begin v = sh % 65536; if (v >= 32768) v = v - 65536; end
         6'h25: v = sh % 65536;
         default: v = word;
      endcase
      return v;
   endfunction

   task automatic run_load(input logic [5:0] op, input logic [31:0] addr, input logic [4:0] rd,
                           input logic [31:0] word, input int k, input bit hold);
      int          size;
      bit          legal;
      bit          ok;
      int          stalls;
      logic [31:0] exp_data;
      size     = op_size(op);
      legal    = (size != 0);
      ok       = legal && (addr % size == 0);
      exp_data = ref_extend(op, addr, word);
      $display("[TB] load op=%02h addr=%08h rd=%0d word=%08h ack_delay=%0d hold=%0d exp=%08h",
               op, addr, rd, word, k, hold, exp_data);

      next_cycle;
      ld_valid = 1'b1; ld_op = op; ld_addr = addr; ld_rd = rd; dm_ack = 1'b0;
      settle;
      check_eq("accept_stall", 32'(ld_stall), 32'(ok));
      check_eq("accept_no_req", 32'(dm_req), 32'd0);
      stalls = ld_stall ? 1 : 0;

      if (!legal) begin
         next_cycle; ld_valid = 1'b0; settle;
         check_eq("illegal_req", 32'(dm_req), 32'd0);
         check_eq("illegal_exc", 32'(ld_exc), 32'd0);
         check_eq("illegal_wb", 32'(wb_valid), 32'd0);
         return;
      end

      if (!ok) begin
         next_cycle; ld_valid = hold; settle;
         check_eq("adel_exc", 32'(ld_exc), 32'd1);
         check_eq("adel_code", 32'(exc_code), 32'd1);
         check_eq("adel_addr", exc_addr, addr);
         check_eq("adel_req", 32'(dm_req), 32'd0);
         check_eq("adel_wb", 32'(wb_valid), 32'd0);
         check_eq("adel_stall", 32'(ld_stall), 32'd0);
         next_cycle; ld_valid = 1'b0; settle;
         check_eq("adel_exc_end", 32'(ld_exc), 32'd0);
         check_eq("adel_code_end", 32'(exc_code), 32'd0);
         check_eq("adel_req_end", 32'(dm_req), 32'd0);
         check_eq("adel_wb_end", 32'(wb_valid), 32'd0);
         return;
      end

      for (int i = 1; i <= k; i++) begin
         next_cycle;
         ld_valid = hold;
         dm_ack   = (i == k);
         dm_rdata = (i == k) ? word : $urandom;
         settle;
         check_eq("wait_req", 32'(dm_req), 32'd1);
         check_eq("wait_addr", dm_addr, addr & 32'hFFFF_FFFC);
         check_eq("wait_wb", 32'(wb_valid), 32'd0);
         check_eq("wait_stall", 32'(ld_stall), 32'd1);
         if (ld_stall) stalls++;
      end

      next_cycle; dm_ack = 1'b0; dm_rdata = $urandom; settle;
      check_eq("done_valid", 32'(wb_valid), 32'd1);
      check_eq("done_data", wb_data, exp_data);
      check_eq("done_rd", 32'(wb_rd), 32'(rd));
      check_eq("done_stall", 32'(ld_stall), 32'd0);
      check_eq("done_req", 32'(dm_req), 32'd0);
      check_eq("stall_cycles", 32'(stalls), 32'(k + 1));

      next_cycle; ld_valid = 1'b0; settle;
      check_eq("post_valid", 32'(wb_valid), 32'd0);
      check_eq("post_no_reissue", 32'(dm_req), 32'd0);
      check_eq("post_data_kept", wb_data, exp_data);
      check_eq("post_rd_kept", 32'(wb_rd), 32'(rd));
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_req"}, 32'(dm_req), 32'd0);
      check_eq({tag, "_addr"}, dm_addr, 32'd0);
      check_eq({tag, "_wbv"}, 32'(wb_valid), 32'd0);
      check_eq({tag, "_wbrd"}, 32'(wb_rd), 32'd0);
      check_eq({tag, "_wbdata"}, wb_data, 32'd0);
      check_eq({tag, "_exc"}, 32'(ld_exc), 32'd0);
      check_eq({tag, "_code"}, 32'(exc_code), 32'd0);
      check_eq({tag, "_excaddr"}, exc_addr, 32'd0);
      check_eq({tag, "_stall"}, 32'(ld_stall), 32'd0);
   endtask

   task automatic do_reset(input int n);
      next_cycle;
      reset = 1'b1; ld_valid = 1'b0; dm_ack = 1'b0;
      repeat (n) next_cycle;
      reset = 1'b0;
   endtask

   localparam logic [31:0] W = 32'h80FF7F01;

   initial begin
      reset = 1'b1; ld_valid = 1'b0; ld_op = 6'd0; ld_addr = 32'd0; ld_rd = 5'd0;
      dm_ack = 1'b0; dm_rdata = 32'd0;
      repeat (3) next_cycle;
      settle;
      check_all_zero("reset");
      reset = 1'b0;

      // Byte loads, ack one cycle after req
      run_load(6'h20, 32'h0000_1003, 5'd3, W, 1, 1'b0);
      run_load(6'h24, 32'h0000_1003, 5'd4, W, 1, 1'b0);
      run_load(6'h20, 32'h0000_1001, 5'd5, W, 1, 1'b0);
      // Halfword and word loads
      run_load(6'h21, 32'h0000_1002, 5'd6, W, 1, 1'b0);
      run_load(6'h25, 32'h0000_1002, 5'd7, W, 1, 1'b0);
      run_load(6'h21, 32'h0000_1000, 5'd8, W, 1, 1'b0);
      run_load(6'h23, 32'h0000_1000, 5'd9, W, 1, 1'b0);
      // Slow ack with ld_valid held throughout, including DONE
      run_load(6'h23, 32'h0000_1000, 5'd10, W, 5, 1'b1);
      // Misaligned and illegal
      run_load(6'h21, 32'h0000_1001, 5'd11, W, 1, 1'b0);
      run_load(6'h23, 32'h0000_1002, 5'd12, W, 1, 1'b1);
      run_load(6'h2b, 32'h0000_1000, 5'd13, W, 1, 1'b0);

      // Reset asserted in the second WAIT cycle, then a late ack
      $display("[TB] reset during WAIT");
      next_cycle; ld_valid = 1'b1; ld_op = 6'h23; ld_addr = 32'h0000_2000; ld_rd = 5'd14; settle;
      next_cycle; ld_valid = 1'b0; settle;
      check_eq("rst_wait1_req", 32'(dm_req), 32'd1);
      next_cycle; reset = 1'b1; settle;
      next_cycle; reset = 1'b0; dm_ack = 1'b1; dm_rdata = W; settle;
      check_all_zero("rst_mid");
      next_cycle; dm_ack = 1'b0; settle;
      check_eq("rst_late_ack_wb", 32'(wb_valid), 32'd0);
      check_eq("rst_late_ack_req", 32'(dm_req), 32'd0);

      // Timeout on the 4-cycle instance; a stray ack afterwards is ignored
      $display("[TB] timeout lhu addr=00003006");
      next_cycle; ld_valid = 1'b1; ld_op = 6'h25; ld_addr = 32'h0000_3006; ld_rd = 5'd15; settle;
      check_eq("to_accept_stall", 32'(to_ld_stall), 32'd1);
      for (int i = 1; i <= 4; i++) begin
         next_cycle; ld_valid = 1'b0; settle;
         check_eq("to_wait_req", 32'(to_dm_req), 32'd1);
         check_eq("to_wait_exc", 32'(to_ld_exc), 32'd0);
      end
      next_cycle; settle;
      check_eq("to_exc", 32'(to_ld_exc), 32'd1);
      check_eq("to_code", 32'(to_exc_code), 32'd2);
      check_eq("to_addr", to_exc_addr, 32'h0000_3006);
      check_eq("to_req_drop", 32'(to_dm_req), 32'd0);
      check_eq("to_wb", 32'(to_wb_valid), 32'd0);
      next_cycle; dm_ack = 1'b1; dm_rdata = W; settle;
      check_eq("to_exc_end", 32'(to_ld_exc), 32'd0);
      check_eq("to_code_end", 32'(to_exc_code), 32'd0);
      next_cycle; dm_ack = 1'b0; settle;
      check_eq("to_stray_wb", 32'(to_wb_valid), 32'd0);
      check_eq("to_stray_req", 32'(to_dm_req), 32'd0);
      do_reset(2);

      // Random loads against the reference model
      for (int n = 0; n < 40; n++) begin
         logic [5:0]  op;
         logic [31:0] addr;
         case ($urandom_range(0, 5))
            0: op = 6'h20;
            1: op = 6'h24;
            2: op = 6'h21;
            3: op = 6'h25;
            4: op = 6'h23;
            default: op = 6'($urandom);
         endcase
         addr = $urandom;
         run_load(op, addr, 5'($urandom), $urandom, $urandom_range(1, 4), 1'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
